// File: rtl/hamming_pkg.sv
// Shared Hamming(21,16) definitions: widths, bit placement and the encode
// function used by both the encoder and the decoder's syndrome logic.
package hamming_pkg;

  localparam int DATA_W = 16;
  localparam int CODE_W = 21;
  localparam int PAR_W  = 5;

  // Codeword indices holding parity bits (Hamming positions 1, 2, 4, 8, 16).
  localparam int PAR_POS [PAR_W] = '{0, 1, 3, 7, 15};

  // Codeword indices holding data bits 0..15, in ascending order.
  localparam int DATA_POS [DATA_W] = '{
    2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20
  };

  // Place the data bits, then fill each parity bit with the even parity of
  // every position whose (1-based) number has that parity's bit set. Parity
  // bit k is still zero while it is being computed, and no other parity
  // position has bit k set, so the in-place scan only ever sees data bits.
  function automatic logic [CODE_W-1:0] hamming_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] code;
    logic              par;
    code = '0;
    for (int i = 0; i < DATA_W; i++) begin
      code[DATA_POS[i]] = data[i];
    end
    for (int k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int j = 0; j < CODE_W; j++) begin
        if (((j + 1) & (1 << k)) != 0) begin
          par = par ^ code[j];
        end
      end
      code[PAR_POS[k]] = par;
    end
    return code;
  endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational Hamming(21,16) encoder feeding the output buffer write port.
module hamming_enc_core
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] i_data,
  output logic [CODE_W-1:0] o_code
);

  // Pure function of the incoming word; no state.
  always_comb begin
    o_code = hamming_encode(i_data);
  end

endmodule

// File: rtl/hamming_enc_stream.sv
// Streaming Hamming(21,16) encoder with a 2-entry output buffer. The
// buffer decouples upstream from downstream so one word can be accepted
// while the channel is stalled. Handshake outputs come from registers only.
module hamming_enc_stream
  import hamming_pkg::*;
#(
  parameter int DEPTH = 2  // only 2 is supported: pointers are 1 bit wide
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] iData,
  input  logic              iValid,
  output logic              oReady,
  output logic [CODE_W-1:0] oData,
  output logic              oValid,
  input  logic              iReady
);

  localparam logic [1:0] COUNT_FULL = 2'(DEPTH);

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic [CODE_W-1:0] w_code;
  logic              w_push;
  logic              w_pop;

  hamming_enc_core u_core (
    .i_data (iData),
    .o_code (w_code)
  );

  // Handshake flags and head data, all derived from registered state.
  always_comb begin
    oReady = (r_count != COUNT_FULL);
    oValid = (r_count != 2'd0);
    oData  = r_mem[r_rd_ptr];
    w_push = iValid && oReady;
    w_pop  = oValid && iReady;
  end

  // Buffer storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared on reset because oData must read as zero
      // straight after reset; a data-only buffer could otherwise skip this.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge pointers and count, regardless of statement order.
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_code;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_enc_stream.sv
// Directed + random bench for hamming_enc_stream. A monitor keeps a
// scoreboard of expected codewords (filled on each accepted push, drained on
// each pop) and runs every popped codeword through a reference decoder with
// one random bit flipped, so encoding is checked end to end.
module tb_hamming_enc_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iData;
  logic        iValid;
  logic        oReady;
  logic [20:0] oData;
  logic        oValid;
  logic        iReady;

  int cmp_count = 0;
  int err_count = 0;
  int n_push    = 0;

  logic [20:0] q_code [$];
  logic [15:0] q_data [$];

  logic [20:0] mon_code;
  logic [15:0] mon_data;
  logic [20:0] mon_rx;
  int          mon_flip;

  logic [15:0] vec_d [3] = '{16'h0000, 16'hffff, 16'h443d};
  logic [20:0] vec_c [3] = '{21'h000000, 21'h1ffffe, 21'h08c3e6};

  always #5 clk = ~clk;

  hamming_enc_stream #(.DEPTH(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .iData  (iData),
    .iValid (iValid),
    .oReady (oReady),
    .oData  (oData),
    .oValid (oValid),
    .iReady (iReady)
  );

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
    cmp_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoder: data fills non-power-of-two positions; the XOR of the
  // positions of all set data bits gives the parity bits directly.
  function automatic logic [20:0] ref_encode(input logic [15:0] d);
    logic [20:0] c;
    int          di;
    int          s;
    c  = '0;
    di = 0;
    s  = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[di];
        if (d[di]) s = s ^ pos;
        di++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      c[(1 << k) - 1] = s[k];
    end
    return c;
  endfunction

  // Reference decoder: the syndrome is the XOR of the positions of all set
  // bits; a nonzero syndrome names the flipped position.
  function automatic logic [15:0] ref_decode(input logic [20:0] c_in);
    logic [20:0] c;
    logic [15:0] d;
    int          s;
    int          di;
    c  = c_in;
    s  = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if (c[pos-1]) s = s ^ pos;
    end
    if (s >= 1 && s <= 21) c[s-1] = ~c[s-1];
    d  = '0;
    di = 0;
    for (int pos = 1; pos <= 21; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[di] = c[pos-1];
        di++;
      end
    end
    return d;
  endfunction

  // Scoreboard monitor, sampling mid-cycle: pops are checked before pushes
  // are recorded since a same-cycle push cannot yet be at the head.
  always @(negedge clk) begin
    if (rst) begin
      q_code.delete();
      q_data.delete();
    end else begin
      if (oValid && iReady) begin
        check("sb_nonempty", {20'b0, q_code.size() != 0}, 21'd1);
        if (q_code.size() != 0) begin
          mon_code = q_code.pop_front();
          mon_data = q_data.pop_front();
          check("sb_oData", oData, mon_code);
          mon_flip = $urandom_range(0, 20);
          mon_rx   = oData;
          mon_rx[mon_flip] = ~mon_rx[mon_flip];
          check("loopback", {5'b0, ref_decode(mon_rx)}, {5'b0, mon_data});
        end
      end
      if (iValid && oReady) begin
        q_code.push_back(ref_encode(iData));
        q_data.push_back(iData);
        n_push++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] w [5];
  int          budget;

  initial begin
    rst    = 1'b1;
    iData  = '0;
    iValid = 1'b0;
    iReady = 1'b0;
    tick();
    tick();
    check("rst_oValid", {20'b0, oValid}, 21'd0);
    check("rst_oReady", {20'b0, oReady}, 21'd1);
    check("rst_oData",  oData, 21'h000000);
    rst = 1'b0;
    tick();

    // Single word, downstream held off for 4 cycles.
    iData  = 16'h443d;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    iData  = 16'hbeef;
    for (int i = 0; i < 4; i++) begin
      check("hold_oValid", {20'b0, oValid}, 21'd1);
      check("hold_oData",  oData, 21'h08c3e6);
      tick();
    end
    iReady = 1'b1;
    tick();
    check("single_empty", {20'b0, oValid}, 21'd0);

    // Known vectors back to back, one per cycle.
    for (int i = 0; i < 3; i++) begin
      iData  = vec_d[i];
      iValid = 1'b1;
      tick();
      check("vec_oValid", {20'b0, oValid}, 21'd1);
      check("vec_oData",  oData, vec_c[i]);
    end
    iValid = 1'b0;
    tick();
    check("vec_empty", {20'b0, oValid}, 21'd0);

    // Fill with downstream stalled; third word waits for a pop.
    for (int i = 0; i < 3; i++) w[i] = 16'($urandom());
    iReady = 1'b0;
    iValid = 1'b1;
    iData  = w[0];
    tick();
    check("full_ready1", {20'b0, oReady}, 21'd1);
    iData = w[1];
    tick();
    check("full_ready0", {20'b0, oReady}, 21'd0);
    iData = w[2];
    tick();
    check("full_stay0", {20'b0, oReady}, 21'd0);
    check("full_head",  oData, ref_encode(w[0]));
    iReady = 1'b1;
    tick();
    check("full_reopen", {20'b0, oReady}, 21'd1);
    check("full_head2",  oData, ref_encode(w[1]));
    iReady = 1'b0;
    tick();
    check("full_again", {20'b0, oReady}, 21'd0);
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    check("full_head3", oData, ref_encode(w[2]));
    tick();
    check("full_empty", {20'b0, oValid}, 21'd0);

    // Simultaneous push and pop at count 1.
    for (int i = 0; i < 5; i++) w[i] = 16'($urandom());
    iReady = 1'b0;
    iValid = 1'b1;
    iData  = w[0];
    tick();
    iReady = 1'b1;
    for (int i = 1; i < 5; i++) begin
      iData = w[i];
      tick();
      check("pp_oValid", {20'b0, oValid}, 21'd1);
      check("pp_oReady", {20'b0, oReady}, 21'd1);
      check("pp_oData",  oData, ref_encode(w[i]));
    end
    iValid = 1'b0;
    tick();
    check("pp_empty", {20'b0, oValid}, 21'd0);

    // Reset with two words buffered; push/pop on the reset edge ignored.
    iReady = 1'b0;
    iValid = 1'b1;
    iData  = 16'h1234;
    tick();
    iData = 16'h5678;
    tick();
    check("mid_full", {20'b0, oReady}, 21'd0);
    rst    = 1'b1;
    iReady = 1'b1;
    iData  = 16'h9abc;
    tick();
    rst    = 1'b0;
    iValid = 1'b0;
    check("mid_oValid", {20'b0, oValid}, 21'd0);
    check("mid_oReady", {20'b0, oReady}, 21'd1);
    check("mid_oData",  oData, 21'h000000);

    // Random loopback traffic with random stalls on both sides.
    n_push = 0;
    budget = 0;
    while (n_push < 1000 && budget < 20000) begin
      iValid = ($urandom_range(0, 3) != 0);
      iReady = ($urandom_range(0, 3) != 0);
      iData  = 16'($urandom());
      tick();
      budget++;
    end
    check("loop_count", {20'b0, n_push >= 1000}, 21'd1);
    iValid = 1'b0;
    iReady = 1'b1;
    for (int i = 0; i < 10 && q_code.size() != 0; i++) tick();
    check("drain_empty", 21'(q_code.size()), 21'd0);
    check("drain_oValid", {20'b0, oValid}, 21'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule

// File: doc/hamming_enc_stream.md
# hamming_enc_stream

Streaming Hamming(21,16) single-error-correcting encoder, the transmit-side counterpart of the 21→16 Hamming decoder. Accepts 16-bit data words over a valid/ready handshake, computes five even-parity bits, and presents 21-bit codewords through a 2-entry output buffer, so an upstream word can be accepted while downstream stalls. Sits between the data source and the channel or decoder input; its output port is directly compatible with the decoder's `iData`/`iValid`/`oReady` input side.

## Interface
Parameters:
- `DEPTH`, 2: output buffer entries; only 2 is supported.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `iData`  in  16  data word to encode.
- `iValid`  in  1  `iData` valid.
- `oReady`  out  1  encoder can accept; high when buffer not full.
- `oData`  out  21  codeword at buffer head.
- `oValid`  out  1  `oData` valid; high when buffer not empty.
- `iReady`  in  1  downstream accepts `oData`.

## Operation
- Codeword bit index i corresponds to Hamming position i+1 (positions 1..21).
- Parity positions 1, 2, 4, 8, 16 → `oData[0]`, `[1]`, `[3]`, `[7]`, `[15]`.
- Data bits `iData[0]`..`iData[15]` fill the remaining positions in ascending order: indices 2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20.
- Parity p_k (k = 1, 2, 4, 8, 16) is the even-parity XOR over all data positions whose position number has bit k set. There is no overall parity bit.
- Push: `iValid && oReady`. The encoded word is written at the write pointer on the clock edge.
- Pop: `oValid && iReady`. The read pointer advances on the clock edge.
- Storage: 2 × 21-bit registers, 1-bit read/write pointers (wrap 1→0), 2-bit count 0..2.
- Simultaneous push and pop:
  - count = 1: count stays 1; head advances; new word lands in the other entry.
  - count = 0: only push is possible (`oValid` = 0).
  - count = 2: only pop is possible (`oReady` = 0).
- `oReady` = (count != 2). `oValid` = (count != 0). Both are driven from registered state only; there is no combinational path from `iReady` to `oReady`.
- `oData` = entry at read pointer. It is held stable while `oValid && !iReady`.
- Words are delivered in order with no loss and no duplication.
- `iData` is ignored whenever no push occurs.

## Timing
- Reset values: count 0, pointers 0, storage 0, `oValid` 0, `oReady` 1, `oData` 21'h000000.
- Reset asserted mid-operation discards all buffered words on that edge. Push/pop at that edge are ignored.
- Latency: a word pushed at edge N is visible on `oData` with `oValid` = 1 after edge N, provided the buffer was empty.
- Throughput: one word per cycle when `iReady` is held high.
- Backpressure: with `iReady` low, two consecutive pushes fill the buffer and `oReady` falls after the second push edge. A pop raises `oReady` on the following cycle.
- A single-cycle `iValid` pulse with downstream held off for several cycles is captured and held until `iReady`.

## Structure
- Package `hamming_pkg`:
  - `DATA_W` = 16, `CODE_W` = 21, `PAR_W` = 5.
  - Parity-position constants and data-position index array.
  - Function `hamming_encode(logic [15:0]) → logic [20:0]`.
- The function is shared with the decoder, which uses it for syndrome recomputation.
- Sub-module `hamming_enc_core`: purely combinational wrapper of `hamming_encode`, instantiated once at the buffer write side. FIFO control and pointers stay in the top.

## Test plan
- Reset then single word: `iData` = 16'h443d with a one-cycle `iValid` and `iReady` = 0 for 4 cycles → `oValid` high from the next cycle, `oData` = 21'h08c3e6 held stable, popped when `iReady` = 1, then `oValid` = 0.
- Known vectors, back-to-back with `iReady` = 1:
  - 16'h0000 → 21'h000000
  - 16'hffff → 21'h1ffffe
  - 16'h443d → 21'h08c3e6
  - Expected: one per cycle, in order.
- Full/backpressure: push 3 words with `iReady` = 0 → first two accepted; `oReady` = 0 after the second, so the third is not taken until a pop; order preserved.
- Simultaneous push/pop at count = 1: count remains 1 and the output sequence is correct.
- Reset mid-stream with 2 words buffered → next cycle `oValid` = 0, `oReady` = 1, `oData` = 0.
- Loopback: random 16-bit words → this block → decoder with random single-bit flips (index 0..20) → decoded data equals the original for 1000 words.
